multimode_time_core: RTL and testbench

//  Parametrised timekeeping engine for the multimode VGA clock: one block holds the
//  24h/12h clock, countdown timer and stopwatch, with all counters running concurrently.
//  It takes debounced single-cycle control pulses and drives BCD time to the

---
 rtl/multimode_time_core_if.sv | 29 ++
 rtl/multimode_time_core.sv | 242 ++++++++++++++++++++++++
 tb/tb_multimode_time_core.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multimode_time_core_if.sv
// Control pulses, set handshake and display bus of the multimode timekeeping core.
// The core connects through the slave modport; the driver of the pulses uses master.
interface multimode_time_core_if;
  logic        mode_step;
  logic        start_stop;
  logic        lap;
  logic        set_valid;
  logic [1:0]  set_field;
  logic [6:0]  set_value;
  logic        set_ready;
  logic [1:0]  mode;
  logic [7:0]  disp_hours;
  logic [7:0]  disp_min;
  logic [7:0]  disp_sec;
  logic [11:0] disp_milli;
  logic        pm;
  logic        running;
  logic        timer_done;

  modport master (
    output mode_step, start_stop, lap, set_valid, set_field, set_value,
    input  set_ready, mode, disp_hours, disp_min, disp_sec, disp_milli, pm, running, timer_done
  );

  modport slave (
    input  mode_step, start_stop, lap, set_valid, set_field, set_value,
    output set_ready, mode, disp_hours, disp_min, disp_sec, disp_milli, pm, running, timer_done
  );
endinterface

// File: rtl/multimode_time_core.sv
// Timekeeping engine: 24h clock, countdown timer and stopwatch all run concurrently
// off a shared 1 ms tick; the mode picks which one is converted to BCD for display.
module multimode_time_core #(
  parameter int TICK_DIV  = 100000,
  parameter int SW_HR_MAX = 99,
  parameter int MODE_W    = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  multimode_time_core_if.slave bus
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [MODE_W-1:0] M_CK24   = MODE_W'(0);
  localparam logic [MODE_W-1:0] M_CK12   = MODE_W'(1);
  localparam logic [MODE_W-1:0] M_TMR    = MODE_W'(2);
  localparam logic [MODE_W-1:0] M_SW     = MODE_W'(3);

  typedef struct packed {
    logic [6:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [9:0] ms;
  } time_t;

  function automatic time_t t_inc(time_t t, logic [6:0] hmax);
    time_t r = t;
    if (t.ms != 10'd999) begin
      r.ms = t.ms + 10'd1;
    end else begin
      r.ms = '0;
      if (t.s != 6'd59) begin
        r.s = t.s + 6'd1;
      end else begin
        r.s = '0;
        if (t.m != 6'd59) begin
          r.m = t.m + 6'd1;
        end else begin
          r.m = '0;
          r.h = (t.h == hmax) ? 7'd0 : t.h + 7'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic time_t t_dec(time_t t);
    time_t r = t;
    if (t.ms != 10'd0) begin
      r.ms = t.ms - 10'd1;
    end else begin
      r.ms = 10'd999;
      if (t.s != 6'd0) begin
        r.s = t.s - 6'd1;
      end else begin
        r.s = 6'd59;
        if (t.m != 6'd0) begin
          r.m = t.m - 6'd1;
        end else begin
          r.m = 6'd59;
          r.h = (t.h == 7'd0) ? 7'd23 : t.h - 7'd1;
        end
      end
    end
    return r;
  endfunction

  // Out-of-range set values saturate at the field maximum; milliseconds restart at 0.
  function automatic time_t t_set(time_t t, logic [1:0] f, logic [6:0] v);
    time_t r = t;
    case (f)
      2'd0: begin r.h = (v > 7'd23) ? 7'd23 : v;      r.ms = '0; end
      2'd1: begin r.m = (v > 7'd59) ? 6'd59 : v[5:0]; r.ms = '0; end
      2'd2: begin r.s = (v > 7'd59) ? 6'd59 : v[5:0]; r.ms = '0; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] to_bcd2(logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  function automatic logic [11:0] to_bcd3(logic [9:0] v);
    return {4'(v / 10'd100), 4'((v / 10'd10) % 10'd10), 4'(v % 10'd10)};
  endfunction

  // Returns {pm, hour 1..12}.
  function automatic logic [7:0] to_12h(logic [6:0] h);
    if (h == 7'd0)       return {1'b0, 7'd12};
    else if (h < 7'd12)  return {1'b0, h};
    else if (h == 7'd12) return {1'b1, 7'd12};
    else                 return {1'b1, h - 7'd12};
  endfunction

  logic [PRE_W-1:0]  r_pre;
  logic [MODE_W-1:0] r_mode;
  logic              r_alive;
  time_t             r_ck, r_tm, r_sw, r_lap;
  logic              r_tm_run, r_sw_run, r_hold, r_done;
  logic [7:0]        r_hours_p1, r_min_p1, r_sec_p1;
  logic [11:0]       r_milli_p1;
  logic              r_pm_p1;

  logic              w_tick, w_set_rdy, w_set_eff;
  time_t             w_ck_nxt, w_tm_nxt, w_sw_nxt, w_lap_nxt, w_show;
  logic              w_tm_run_nxt, w_done_nxt, w_sw_run_nxt, w_hold_nxt;
  logic [MODE_W-1:0] w_mode_nxt;
  logic [6:0]        w_hr_show;
  logic              w_pm;

  assign w_tick    = (r_pre == PRE_LAST);
  assign w_set_rdy = r_alive & ((r_mode == M_CK24) | (r_mode == M_CK12) |
                                ((r_mode == M_TMR) & ~r_tm_run));
  // Field 3 is handshaken but must leave every counter and flag untouched.
  assign w_set_eff = bus.set_valid & w_set_rdy & (bus.set_field != 2'd3);

  always_comb begin
    w_ck_nxt = r_ck;
    if (w_set_eff && (r_mode == M_CK24 || r_mode == M_CK12))
      w_ck_nxt = t_set(r_ck, bus.set_field, bus.set_value);
    else if (w_tick)
      w_ck_nxt = t_inc(r_ck, 7'd23);
  end

  always_comb begin
    w_tm_nxt     = r_tm;
    w_tm_run_nxt = r_tm_run;
    w_done_nxt   = r_done;
    if (w_set_eff && r_mode == M_TMR) begin
      w_tm_nxt   = t_set(r_tm, bus.set_field, bus.set_value);
      w_done_nxt = 1'b0;
    end else if (w_tick && r_tm_run) begin
      w_tm_nxt = t_dec(r_tm);
    end
    if (bus.start_stop && r_mode == M_TMR) begin
      if (r_tm_run) begin
        w_tm_run_nxt = 1'b0;
      end else if (w_tm_nxt != '0) begin
        w_tm_run_nxt = 1'b1;
        w_done_nxt   = 1'b0;
      end
    end
    // Expiry wins over any coincident start_stop.
    if (w_tick && r_tm_run && w_tm_nxt == '0) begin
      w_tm_run_nxt = 1'b0;
      w_done_nxt   = 1'b1;
    end
  end

  always_comb begin
    w_sw_nxt     = r_sw;
    w_lap_nxt    = r_lap;
    w_hold_nxt   = r_hold;
    w_sw_run_nxt = r_sw_run;
    if (bus.lap && r_mode == M_SW) begin
      if (r_sw_run) begin
        w_hold_nxt = ~r_hold;
        if (!r_hold) w_lap_nxt = r_sw;
      end else begin
        w_sw_nxt   = '0;
        w_hold_nxt = 1'b0;
      end
    end
    if (w_tick && r_sw_run) w_sw_nxt = t_inc(r_sw, 7'(SW_HR_MAX));
    if (bus.start_stop && r_mode == M_SW) w_sw_run_nxt = ~r_sw_run;
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (bus.mode_step) w_mode_nxt = (r_mode == M_SW) ? M_CK24 : r_mode + MODE_W'(1);
  end

  always_comb begin
    w_show = r_ck;
    case (r_mode)
      M_TMR:   w_show = r_tm;
      M_SW:    w_show = r_hold ? r_lap : r_sw;
      default: ;
    endcase
    w_hr_show = w_show.h;
    w_pm      = 1'b0;
    if (r_mode == M_CK12) {w_pm, w_hr_show} = to_12h(r_ck.h);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pre    <= '0;
      r_mode   <= '0;
      r_alive  <= 1'b0;
      r_ck     <= '0;
      r_tm     <= '0;
      r_sw     <= '0;
      r_lap    <= '0;
      r_tm_run <= 1'b0;
      r_sw_run <= 1'b0;
      r_hold   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_pre    <= w_tick ? '0 : r_pre + PRE_W'(1);
      r_mode   <= w_mode_nxt;
      r_alive  <= 1'b1;
      r_ck     <= w_ck_nxt;
      r_tm     <= w_tm_nxt;
      r_sw     <= w_sw_nxt;
      r_lap    <= w_lap_nxt;
      r_tm_run <= w_tm_run_nxt;
      r_sw_run <= w_sw_run_nxt;
      r_hold   <= w_hold_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Display stage p1: BCD of the counter state selected in the previous cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hours_p1 <= '0;
      r_min_p1   <= '0;
      r_sec_p1   <= '0;
      r_milli_p1 <= '0;
      r_pm_p1    <= 1'b0;
    end else begin
      r_hours_p1 <= to_bcd2(w_hr_show);
      r_min_p1   <= to_bcd2({1'b0, w_show.m});
      r_sec_p1   <= to_bcd2({1'b0, w_show.s});
      r_milli_p1 <= to_bcd3(w_show.ms);
      r_pm_p1    <= w_pm;
    end
  end

  assign bus.set_ready  = w_set_rdy;
  assign bus.mode       = 2'(r_mode);
  assign bus.disp_hours = r_hours_p1;
  assign bus.disp_min   = r_min_p1;
  assign bus.disp_sec   = r_sec_p1;
  assign bus.disp_milli = r_milli_p1;
  assign bus.pm         = r_pm_p1;
  assign bus.running    = ((r_mode == M_TMR) & r_tm_run) | ((r_mode == M_SW) & r_sw_run);
  assign bus.timer_done = r_done;

endmodule

// File: tb/tb_multimode_time_core.sv
// Bench for multimode_time_core: directed scenarios plus random pulses, every cycle
// compared with a millisecond-count reference model.
module tb_multimode_time_core;
  localparam int TD    = 4;
  localparam int SWH   = 99;
  localparam int DAY   = 86400000;
  localparam int SWMOD = (SWH + 1) * 3600000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_chk = 0, n_pass = 0, n_fail = 0;

  multimode_time_core_if bus ();

  multimode_time_core #(.TICK_DIV(TD), .SW_HR_MAX(SWH), .MODE_W(2)) dut (
    .clk(clk), .resetn(resetn), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [41:0] w_obs;
  assign w_obs = {bus.set_ready, bus.mode, bus.disp_hours, bus.disp_min, bus.disp_sec,
                  bus.disp_milli, bus.pm, bus.running, bus.timer_done};

  // Reference model: every counter is a plain millisecond count.
  int m_pre, m_mode, m_ck, m_tm, m_sw, m_lap;
  bit m_tm_run, m_sw_run, m_hold, m_done, m_alive;
  logic [36:0] m_disp;

  function automatic logic [7:0] bcd2(int v);
    logic [7:0] r;
    string s;
    s = $sformatf("%02d", v);
    void'($sscanf(s, "%h", r));
    return r;
  endfunction

  function automatic logic [11:0] bcd3(int v);
    logic [11:0] r;
    string s;
    s = $sformatf("%03d", v);
    void'($sscanf(s, "%h", r));
    return r;
  endfunction

  function automatic logic [36:0] disp_of(int t, bit twelve);
    int h = t / 3600000;
    bit pm = 1'b0;
    if (twelve) begin
      pm = (h >= 12);
      h = h % 12;
      if (h == 0) h = 12;
    end
    return {bcd2(h), bcd2((t / 60000) % 60), bcd2((t / 1000) % 60), bcd3(t % 1000), pm};
  endfunction

  function automatic int set_val(int t, int f, int v);
    int h = t / 3600000, m = (t / 60000) % 60, s = (t / 1000) % 60;
    if (f == 0) h = (v > 23) ? 23 : v;
    if (f == 1) m = (v > 59) ? 59 : v;
    if (f == 2) s = (v > 59) ? 59 : v;
    return h * 3600000 + m * 60000 + s * 1000;
  endfunction

  function automatic logic [41:0] exp_vec();
    bit rdy = m_alive && (m_mode < 2 || (m_mode == 2 && !m_tm_run));
    bit run = (m_mode == 2 && m_tm_run) || (m_mode == 3 && m_sw_run);
    return {rdy, 2'(m_mode), m_disp, run, m_done};
  endfunction

  task automatic model_reset();
    m_pre = 0; m_mode = 0; m_ck = 0; m_tm = 0; m_sw = 0; m_lap = 0;
    m_tm_run = 0; m_sw_run = 0; m_hold = 0; m_done = 0; m_alive = 0; m_disp = '0;
  endtask

  task automatic model_edge(bit ms, bit ss, bit lp, bit sv, int sf, int sval);
    bit tick, acc, tm_run0, sw_run0;
    int om;
    if (!resetn) begin
      model_reset();
      return;
    end
    tick = (m_pre == TD - 1);
    om   = m_mode;
    case (om)
      0:       m_disp = disp_of(m_ck, 1'b0);
      1:       m_disp = disp_of(m_ck, 1'b1);
      2:       m_disp = disp_of(m_tm, 1'b0);
      default: m_disp = disp_of(m_hold ? m_lap : m_sw, 1'b0);
    endcase
    acc = sv && sf != 3 && m_alive && (om < 2 || (om == 2 && !m_tm_run));
    tm_run0 = m_tm_run;
    sw_run0 = m_sw_run;
    if (acc && om < 2) m_ck = set_val(m_ck, sf, sval);
    else if (tick)     m_ck = (m_ck + 1) % DAY;
    if (acc && om == 2) begin
      m_tm = set_val(m_tm, sf, sval);
      m_done = 0;
    end else if (tick && tm_run0) begin
      m_tm = m_tm - 1;
    end
    if (ss && om == 2) begin
      if (tm_run0) m_tm_run = 0;
      else if (m_tm != 0) begin m_tm_run = 1; m_done = 0; end
    end
    if (tick && tm_run0 && m_tm == 0) begin m_tm_run = 0; m_done = 1; end
    if (lp && om == 3) begin
      if (sw_run0) begin
        if (!m_hold) m_lap = m_sw;
        m_hold = !m_hold;
      end else begin
        m_sw = 0;
        m_hold = 0;
      end
    end
    if (tick && sw_run0) m_sw = (m_sw + 1) % SWMOD;
    if (ss && om == 3) m_sw_run = !sw_run0;
    if (ms) m_mode = (om + 1) % 4;
    m_pre = tick ? 0 : m_pre + 1;
    m_alive = 1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input bit ms, input bit ss, input bit lp, input bit sv,
                     input int sf, input int sval);
    bus.mode_step  = ms;
    bus.start_stop = ss;
    bus.lap        = lp;
    bus.set_valid  = sv;
    bus.set_field  = 2'(sf);
    bus.set_value  = 7'(sval);
    @(posedge clk);
    model_edge(ms, ss, lp, sv, sf, sval);
    @(negedge clk);
    bus.mode_step = 0; bus.start_stop = 0; bus.lap = 0; bus.set_valid = 0;
    chk("cycle", w_obs, exp_vec());
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0);
  endtask
  task automatic step_mode();      cyc(1, 0, 0, 0, 0, 0); endtask
  task automatic press_ss();       cyc(0, 1, 0, 0, 0, 0); endtask
  task automatic press_lap();      cyc(0, 0, 1, 0, 0, 0); endtask
  task automatic do_set(input int f, input int v); cyc(0, 0, 0, 1, f, v); endtask

  initial begin
    bus.mode_step = 0; bus.start_stop = 0; bus.lap = 0; bus.set_valid = 0;
    bus.set_field = 0; bus.set_value = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_outputs", w_obs, 0);
    resetn = 1'b1;

    // Clock counting from reset (display lags state by one cycle)
    idle(4001);
    chk("t1_1s", {bus.disp_hours, bus.disp_min, bus.disp_sec, bus.disp_milli}, 36'h000001000);
    idle(3000);
    chk("t1_1750", {bus.disp_hours, bus.disp_min, bus.disp_sec, bus.disp_milli}, 36'h000001750);

    // Clock set and midnight wrap, then 12h view
    do_set(0, 23); do_set(1, 59); do_set(2, 59);
    idle(2);
    chk("t2_set", {bus.disp_hours, bus.disp_min, bus.disp_sec}, 24'h235959);
    idle(3999);
    chk("t2_wrap", {bus.disp_hours, bus.disp_min, bus.disp_sec, bus.disp_milli}, 36'h0);
    step_mode();
    do_set(0, 13);
    idle(2);
    chk("t2_12h_hour", bus.disp_hours, 8'h01);
    chk("t2_12h_pm", bus.pm, 1);

    // Countdown expiry
    step_mode();
    do_set(1, 0); do_set(2, 2);
    press_ss();
    chk("t3_running", bus.running, 1);
    idle(8002);
    chk("t3_done", {bus.timer_done, bus.running}, 2'b10);
    chk("t3_zero", {bus.disp_hours, bus.disp_min, bus.disp_sec, bus.disp_milli}, 36'h0);
    press_ss();
    chk("t3_ss_ignored", {bus.timer_done, bus.running}, 2'b10);
    do_set(2, 5);
    chk("t3_set_clears", bus.timer_done, 0);

    // Stopwatch lap hold and clear
    step_mode();
    press_ss();
    idle(6000);
    press_lap();
    idle(3);
    chk("t4_frozen", {bus.disp_sec, bus.disp_milli}, 20'h01500);
    chk("t4_still_running", bus.running, 1);
    press_lap();
    idle(40);
    chk("t4_live", bus.disp_milli != 12'h500, 1);
    press_ss();
    press_lap();
    idle(2);
    chk("t4_cleared", {bus.disp_hours, bus.disp_min, bus.disp_sec, bus.disp_milli}, 36'h0);

    // Set clamping and set refusal in stopwatch mode
    step_mode();
    do_set(1, 75);
    idle(2);
    chk("t5_clamp", bus.disp_min, 8'h59);
    step_mode(); step_mode(); step_mode();
    bus.set_valid = 1; bus.set_field = 2'd1; bus.set_value = 7'd10;
    #1;
    chk("t5_ready_mode3", bus.set_ready, 0);
    cyc(0, 0, 0, 1, 1, 10);
    step_mode();

    // Random pulse traffic
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 99);
      cyc(r < 4, r >= 4 && r < 10, r >= 10 && r < 16, r >= 16 && r < 40,
          $urandom_range(0, 3), $urandom_range(0, 127));
    end

    // Mode cycling with the timer running, then asynchronous reset mid-countdown
    for (int i = 0; i < 4 && m_mode != 2; i++) step_mode();
    if (m_tm_run) press_ss();
    do_set(0, 0); do_set(1, 0); do_set(2, 30);
    press_ss();
    repeat (4) step_mode();
    idle(3);
    chk("t6_mode_back", {bus.mode, bus.running}, 3'b101);
    chk("t6_counting", bus.disp_sec, 8'h29);
    #2 resetn = 1'b0;
    #1;
    chk("t6_async_reset", w_obs, 0);
    model_reset();
    @(negedge clk);
    idle(2);
    resetn = 1'b1;
    idle(10);
    chk("t6_after_reset", {bus.mode, bus.running, bus.timer_done}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
